sram_like_arbiter: RTL
======================

# sram_like_arbiter

Shares one sram-like memory port between the CPU core's instruction-fetch and data-access requesters and sequences each transaction through request, address and data phases. It sits between the core's inst/data sram-like master interfaces and the single downstream port that feeds the cache/AXI bridge. It keeps at most one transaction outstanding downstream and routes handshakes and read data back to the granted requester.

## Interface
- No parameters; address and data are 32 bits, size is 2 bits (0 = byte, 1 = half, 2 = word).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req, inst_wr  in  1 each  fetch request; write flag (fetch always drives 0, honoured anyway).
- inst_size  in  2;  inst_addr, inst_wdata  in  32 each.
- inst_addr_ok, inst_data_ok  out  1 each;  inst_rdata  out  32.
- data_req, data_wr  in  1 each;  data_size  in  2;  data_addr, data_wdata  in  32 each.
- data_addr_ok, data_data_ok  out  1 each;  data_rdata  out  32.
- m_req, m_wr  out  1 each;  m_size  out  2;  m_addr, m_wdata  out  32 each  downstream request.
- m_addr_ok, m_data_ok  in  1 each;  m_rdata  in  32  downstream responses.

## Operation
- States: IDLE, ADDR (m_req=1, waiting m_addr_ok), DATA (waiting m_data_ok).
- Arbitration: fixed priority, data over inst. A grant happens when the FSM is in IDLE, or in DATA in the cycle m_data_ok=1, and at least one of data_req/inst_req is 1.
- On grant: latch grant id (0 = inst, 1 = data) and the winner's wr/size/addr/wdata into holding registers; next state ADDR. m_wr/m_size/m_addr/m_wdata are driven only from the holding registers, so they stay stable for the whole ADDR phase.
- ADDR: m_req=1. When m_addr_ok=1: the granted requester's x_addr_ok=1 (combinational, same cycle), and the next state is DATA. The other requester's addr_ok stays 0.
- DATA: m_req=0. When m_data_ok=1: the granted requester's x_data_ok=1 and x_rdata=m_rdata (same cycle). Then the FSM re-arbitrates the same cycle. With no request, the next state is IDLE. With a request, it grants and goes to ADDR.
- m_data_ok is ignored outside DATA. m_addr_ok is ignored outside ADDR.
- inst_rdata and data_rdata both always mirror m_rdata. Only the data_ok strobes qualify them.
- Requester rule: a requester holds req and its fields until its addr_ok. A losing requester simply waits and is not acknowledged.
- Writes follow the identical sequence. data_ok marks write completion, and rdata is don't-care.

## Timing
- Reset values: state IDLE, grant 0, holding registers 0, m_req 0, m_wr 0, m_size 0, m_addr 0, m_wdata 0, all addr_ok/data_ok 0.
- Latency from idle: a req sampled in IDLE at edge N gives m_req=1 in cycle N+1. The earliest addr_ok is in cycle N+1, and the earliest data_ok is in cycle N+2.
- Back-to-back: a grant in the m_data_ok cycle gives m_req=1 the very next cycle, with no idle bubble.
- Simultaneous inst_req and data_req: data is served first. inst is granted at the completion of the data transaction if inst_req is still 1.
- A requester that asserts a new req in the same cycle as its own data_ok is eligible in that cycle's arbitration.
- Downstream must not assert m_data_ok in the same cycle as m_addr_ok. Such an m_data_ok is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, m_req and all strobes drop asynchronously, and the outstanding transaction is discarded. Downstream is reset by the same rst.

## Test plan
- Single fetch: inst_req=1, inst_addr=0xBFC00000, size=2. Downstream gives addr_ok in the first ADDR cycle and data_ok one cycle later with rdata=0x3C08BFAF. Required: m_addr=0xBFC00000, inst_addr_ok one pulse, inst_data_ok one pulse with inst_rdata=0x3C08BFAF, data_* strobes stay 0, FSM returns to IDLE.
- Contention: inst_req and data_req both rise in the same cycle, with data a write to 0x80001000, wdata 0x12345678, size 0. Required: the first m_req carries m_wr=1, m_addr=0x80001000, m_size=0. The second m_req, issued the cycle after the first data_ok, carries the inst address.
- Stall on addr_ok: hold m_addr_ok=0 for 5 cycles while data_req is granted and change data_addr upstream after the grant. Required: m_req=1 for all 6 cycles and m_addr stays at the latched value.
- Back-to-back fetches: inst_req held high over 3 transactions. Required: no IDLE cycle between them, and m_req returns the cycle after each m_data_ok.
- Spurious responses: pulse m_data_ok in IDLE and in ADDR, and pulse m_addr_ok in DATA. Required: no upstream strobe and no state change.
- Reset mid-DATA: assert rst while waiting m_data_ok. Required: all outputs go to reset values without waiting for a clock edge, and after release a new inst_req is served normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Purpose : shares one sram-like downstream port between the inst-fetch and data requesters.
// Latency : req sampled in IDLE -> m_req next cycle; back-to-back grants in the m_data_ok cycle, no bubble.
// Backpr. : one transaction outstanding; losers (and the winner until addr_ok) simply hold req.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   inst_* / data_*               upstream sram-like masters (req, wr, size, addr, wdata -> addr_ok, data_ok, rdata)
//   m_*                           downstream sram-like slave port (req, wr, size, addr, wdata <- addr_ok, data_ok, rdata)
//
// State: IDLE (nothing outstanding), ADDR (m_req high, waiting m_addr_ok),
// DATA (address accepted, waiting m_data_ok). Data requests beat inst requests.

module sram_like_arbiter (
    input  logic        clk,
    input  logic        rst,

    // instruction-fetch requester
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // data-access requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    // downstream port
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    // Request fields latched at grant time; the downstream port is driven
    // only from here so it stays stable while m_addr_ok is stalled.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t state_q, state_nxt;
    req_t   hold_q,  hold_nxt;
    logic   grant_q, grant_nxt;

    req_t   inst_fields;
    req_t   data_fields;
    logic   arb_en;
    logic   any_req;

    assign inst_fields = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_fields = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign any_req     = inst_req | data_req;

    // ------------------------------------------------------------------
    // State and holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            grant_q <= GRANT_INST;
        end else begin
            state_q <= state_nxt;
            hold_q  <= hold_nxt;
            grant_q <= grant_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, arbitration and upstream strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state_q;
        hold_nxt     = hold_q;
        grant_nxt    = grant_q;
        arb_en       = 1'b0;
        m_req        = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
            end

            ST_ADDR: begin
                m_req = 1'b1;
                // m_data_ok is not looked at here, so a response overlapping
                // the address handshake is dropped.
                if (m_addr_ok) begin
                    inst_addr_ok = (grant_q == GRANT_INST);
                    data_addr_ok = (grant_q == GRANT_DATA);
                    state_nxt    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (m_data_ok) begin
                    inst_data_ok = (grant_q == GRANT_INST);
                    data_data_ok = (grant_q == GRANT_DATA);
                    // Completion cycle doubles as an arbitration slot so a
                    // waiting requester issues next cycle without an IDLE bubble.
                    arb_en       = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (arb_en && any_req) begin
            state_nxt = ST_ADDR;
            if (data_req) begin
                grant_nxt = GRANT_DATA;
                hold_nxt  = data_fields;
            end else begin
                grant_nxt = GRANT_INST;
                hold_nxt  = inst_fields;
            end
        end
    end

    // ------------------------------------------------------------------
    // Downstream request fields and read-data fan-out
    // ------------------------------------------------------------------
    assign m_wr    = hold_q.wr;
    assign m_size  = hold_q.size;
    assign m_addr  = hold_q.addr;
    assign m_wdata = hold_q.wdata;

    // Read data is broadcast; only the data_ok strobes qualify it.
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

endmodule
